// File: rtl/param_sync_updown_counter.sv
// Parametrised synchronous up/down counter with programmable modulus, parallel load,
// count enable, terminal-count and wrap flags. Define COUNTER_SATURATE_EN to saturate instead of wrap.
module param_sync_updown_counter #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    // The terminal checks use >= / > so a corrupted q above MAX_VAL recovers like a terminal value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (q >= MAX_VAL) begin
`ifdef COUNTER_SATURATE_EN
                    q_next = MAX_VAL;
`else
                    q_next = '0;
`endif
                    wrap_next = 1'b1;
                end else begin
                    q_next = q + ONE;
                end
            end else begin
                if (q > MAX_VAL) begin
                    q_next    = MAX_VAL;
                    wrap_next = 1'b1;
                end else if (q == '0) begin
`ifdef COUNTER_SATURATE_EN
                    q_next = '0;
`else
                    q_next = MAX_VAL;
`endif
                    wrap_next = 1'b1;
                end else begin
                    q_next = q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

    assign tc = en & ((up & (q == MAX_VAL)) | (~up & (q == '0)));

endmodule

// File: tb/tb_param_sync_updown_counter.sv
// Directed self-checking bench: a WIDTH=4/MAX_VAL=9 instance and a default WIDTH=8 instance.
module tb_param_sync_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] load_val, q;
    logic       tc, wrap;
    logic       en8, up8, load8;
    logic [7:0] load_val8, q8;
    logic       tc8, wrap8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    param_sync_updown_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .up(up8), .load(load8),
        .load_val(load_val8), .q(q8), .tc(tc8), .wrap(wrap8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_val8 = '0;
        tick();
        checks++; if (q !== 4'd0) begin failures++; $display("FAIL reset_q: got %0d expected 0", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc_en0: got %b expected 0", tc); end
        checks++; if (q8 !== 8'd0) begin failures++; $display("FAIL reset_q8: got %0d expected 0", q8); end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic [3:0] prev = 4'd0;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tc !== (prev == 4'd9)) begin failures++; $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, prev == 4'd9); end
            tick();
            checks++;
            if (q !== seq[i]) begin failures++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q, seq[i]); end
            checks++;
            if (wrap !== (i == 9)) begin failures++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, i == 9); end
            prev = seq[i];
        end
    endtask

    task automatic test_count_down();
        logic [3:0] seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        logic [3:0] prev = 4'd3;
        load = 1'b1; load_val = 4'd3; en = 1'b0;
        tick();
        checks++; if (q !== 4'd3) begin failures++; $display("FAIL load3_q: got %0d expected 3", q); end
        load = 1'b0; up = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tc !== (prev == 4'd0)) begin failures++; $display("FAIL dn_tc[%0d]: got %b expected %b", i, tc, prev == 4'd0); end
            tick();
            checks++;
            if (q !== seq[i]) begin failures++; $display("FAIL dn_q[%0d]: got %0d expected %0d", i, q, seq[i]); end
            checks++;
            if (wrap !== (i == 3)) begin failures++; $display("FAIL dn_wrap[%0d]: got %b expected %b", i, wrap, i == 3); end
            prev = seq[i];
        end
    endtask

    task automatic test_load_clamp();
        en = 1'b0; load = 1'b1; load_val = 4'd14;
        tick();
        checks++; if (q !== 4'd9) begin failures++; $display("FAIL clamp14_q: got %0d expected 9", q); end
        load_val = 4'd15;
        tick();
        checks++; if (q !== 4'd9) begin failures++; $display("FAIL clamp15_q: got %0d expected 9", q); end
        // at q=9 with en/up high, load must win over the pending wrap
        load_val = 4'd5; en = 1'b1; up = 1'b1;
        tick();
        checks++; if (q !== 4'd5) begin failures++; $display("FAIL load_over_en_q: got %0d expected 5", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL load_over_en_wrap: got %b expected 0", wrap); end
        load = 1'b0;
    endtask

    task automatic test_reset_override();
        reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7;
        tick();
        checks++; if (q !== 4'd0) begin failures++; $display("FAIL rst_over_q: got %0d expected 0", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rst_over_wrap: got %b expected 0", wrap); end
        reset = 1'b0; load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== 4'd0) begin failures++; $display("FAIL hold_q[%0d]: got %0d expected 0", i, q); end
        end
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; reset = 1'b1; en = 1'b1; up = 1'b1;
        tick();
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rst_at_tc_wrap: got %b expected 0", wrap); end
        reset = 1'b0;
    endtask

    task automatic test_direction_change();
        load = 1'b1; load_val = 4'd4; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++; if (q !== 4'd5) begin failures++; $display("FAIL dir_up_q: got %0d expected 5", q); end
        up = 1'b0;
        tick();
        checks++; if (q !== 4'd4) begin failures++; $display("FAIL dir_dn_q: got %0d expected 4", q); end
        up = 1'b1;
        tick();
        checks++; if (q !== 4'd5) begin failures++; $display("FAIL dir_up2_q: got %0d expected 5", q); end
    endtask

    task automatic test_terminal_mode();
`ifdef COUNTER_SATURATE_EN
        logic [3:0] seq  [3] = '{4'd9, 4'd9, 4'd9};
        logic       wseq [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] after_down = 4'd8;
        logic [3:0] from_zero  = 4'd0;
`else
        logic [3:0] seq  [3] = '{4'd9, 4'd0, 4'd1};
        logic       wseq [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] after_down = 4'd0;
        logic [3:0] from_zero  = 4'd9;
`endif
        load = 1'b1; load_val = 4'd8; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== seq[i]) begin failures++; $display("FAIL term_q[%0d]: got %0d expected %0d", i, q, seq[i]); end
            checks++; if (wrap !== wseq[i]) begin failures++; $display("FAIL term_wrap[%0d]: got %b expected %b", i, wrap, wseq[i]); end
        end
        up = 1'b0;
        tick();
        checks++; if (q !== after_down) begin failures++; $display("FAIL term_down_q: got %0d expected %0d", q, after_down); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL term_down_wrap: got %b expected 0", wrap); end
        load = 1'b1; load_val = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        checks++; if (q !== from_zero) begin failures++; $display("FAIL zero_down_q: got %0d expected %0d", q, from_zero); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL zero_down_wrap: got %b expected 1", wrap); end
        en = 1'b0;
    endtask

    task automatic test_width8();
`ifdef COUNTER_SATURATE_EN
        logic [7:0] up_exp = 8'd255;
        logic [7:0] dn_exp = 8'd0;
`else
        logic [7:0] up_exp = 8'd0;
        logic [7:0] dn_exp = 8'd255;
`endif
        load8 = 1'b1; load_val8 = 8'd255; en8 = 1'b0;
        tick();
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
        #1;
        checks++; if (tc8 !== 1'b1) begin failures++; $display("FAIL w8_tc_top: got %b expected 1", tc8); end
        tick();
        checks++; if (q8 !== up_exp) begin failures++; $display("FAIL w8_up_q: got %0d expected %0d", q8, up_exp); end
        checks++; if (wrap8 !== 1'b1) begin failures++; $display("FAIL w8_up_wrap: got %b expected 1", wrap8); end
        load8 = 1'b1; load_val8 = 8'd0; en8 = 1'b0;
        tick();
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b0;
        tick();
        checks++; if (q8 !== dn_exp) begin failures++; $display("FAIL w8_dn_q: got %0d expected %0d", q8, dn_exp); end
        checks++; if (wrap8 !== 1'b1) begin failures++; $display("FAIL w8_dn_wrap: got %b expected 1", wrap8); end
        en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_reset_override();
        test_direction_change();
        test_terminal_mode();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
